register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised general-purpose register file for the single-cycle RISC-V datapath, generalising the fixed 32x32, two-read-port file. Adds a configurable read-port count, an optional hardwired-zero entry 0, optional write-to-read bypass, and a sequenced flush. The flush clears one entry per cycle on request, so software-visible state can be wiped without asserting reset. It sits between decode (addresses) and the ALU/writeback path (data).

## Interface
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle accepted write is forwarded to matching read ports
- clk  input  1  single clock, rising edge
- clear  input  1  asynchronous, active-low reset
- write_en  input  1  write request
- write_add  input  ADDR_W  write address
- write_reg  input  DATA_W  write data
- read_add  input  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- out_reg  output  NUM_RD*DATA_W  packed read data; port p uses bits [p*DATA_W +: DATA_W]
- wr_accept  output  1  combinational: write_en && !busy
- flush_req  input  1  start-flush request, sampled on clk
- busy  output  1  flush in progress
- flush_done  output  1  one-cycle pulse after the last entry is cleared

## Operation
- Reset (clear=0, asynchronous): all DEPTH entries are 0, state is IDLE, the flush counter is 0, busy=0 and flush_done=0. With the array at zero, every out_reg lane reads 0.
- Write: on a rising edge with wr_accept=1, entry write_add takes write_reg.
  - With ZERO_REG=1, a write to address 0 is accepted (wr_accept=1) but discarded.
  - A write while busy=1 is dropped (wr_accept=0); there is no queueing.
- Read: each port is combinational from the array.
  - With ZERO_REG=1, address 0 returns 0 regardless of stored contents.
  - With BYPASS=1, if wr_accept=1 and write_add equals read_add[p], port p returns write_reg. Exception: ZERO_REG=1 and the address is 0, in which case the port returns 0.
  - With BYPASS=0, port p returns the pre-edge contents.
- During a flush, reads return the current array contents: entries below the counter are already 0, the rest hold old data. No bypass occurs, because wr_accept=0.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when flush_req=1 at an edge; the counter loads 0.
  - FLUSH: at each edge, entry[counter] is set to 0 and the counter increments.
  - When counter = DEPTH-1 at an edge, that entry is cleared, the state returns to IDLE, the counter returns to 0, and flush_done=1 for the next cycle.
  - flush_req while in FLUSH is ignored; there is no restart and no extension.
- Simultaneous write_en and flush_req in IDLE: the write commits at that edge and the flush starts. The written entry is cleared later by the flush.
- flush_req at the same edge that ends a flush: the request is ignored because the state at that edge is FLUSH. A new request is honoured from the following edge.
- An asynchronous reset during FLUSH aborts the flush immediately. All entries are 0, busy=0, flush_done=0, and no pulse is emitted.
- Address width is exact: there is no out-of-range case, because DEPTH = 2**ADDR_W.

## Timing
- Write latency: 1 edge. Read latency: 0 (combinational); with BYPASS=1 the new data is visible in the same cycle.
- Flush requested at edge k:
  - busy=1 from just after edge k until just after edge k+DEPTH.
  - Entries are cleared at edges k+1 .. k+DEPTH, in ascending order.
  - flush_done=1 for exactly the cycle after edge k+DEPTH.
- busy and flush_done are registered and glitch-free; wr_accept is combinational from write_en and busy.
- Back-to-back writes are sustained at one per cycle in IDLE.

## Structure
- Package regfile_pkg:
  - state enum {IDLE, FLUSH}.
  - Default-width constants REG_DATA_W=32 and REG_ADDR_W=5.
  - A function that extracts lane p from a packed bus.
- Sub-module regfile_flush_ctrl:
  - Holds the FSM and the ADDR_W-bit counter.
  - Outputs busy, flush_done, clr_en and clr_add to the array.
  - The array logic stays in register_file_param, with a per-entry write from either the clear port or the write port; the two are mutually exclusive by construction.
- Read ports are built with a generate loop over NUM_RD.

## Test plan
- Reset, then write 0xDEADBEEF to address 5 and read it on ports 0 and 1 the next cycle -> both lanes read 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to address 0 -> wr_accept=1 and address 0 reads 0 in the same cycle and afterwards.
- BYPASS=1: write 0xA5A5A5A5 to address 7 while read_add[0]=7 -> out lane 0 = 0xA5A5A5A5 in the same cycle. BYPASS=0 -> the old value until the next cycle.
- Fill all 32 entries with value = address+1, pulse flush_req:
  - busy=1 for exactly 32 cycles and flush_done pulses once.
  - All entries read 0 afterwards.
  - A write issued mid-flush has wr_accept=0 and does not land.
- Same-edge write_en (address 3, 0x55) and flush_req in IDLE -> 0x55 is readable during the flush until entry 3 is cleared; it reads 0 after flush_done.
- Assert clear at flush cycle 10 -> all entries 0 immediately, busy=0, and flush_done never pulses.
- Reset, then set NUM_RD=3 and ADDR_W=4 -> three lanes read independently and the flush takes 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its flush sequencer.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    // Widest packed bus / lane the lane extractor is sized for (4 ports x 64 bits).
    localparam int LANE_BUS_W = 256;
    localparam int LANE_MAX_W = 64;

    function automatic logic [LANE_MAX_W-1:0] get_lane(
        input logic [LANE_BUS_W-1:0] bus,
        input int                    lane,
        input int                    lane_w
    );
        logic [LANE_BUS_W-1:0] shifted;
        logic [LANE_BUS_W-1:0] mask;
        shifted = bus >> (lane * lane_w);
        mask    = ~({LANE_BUS_W{1'b1}} << lane_w);
        return LANE_MAX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/regfile_flush_ctrl.sv
// Flush sequencer: walks a counter over every entry, clearing one per cycle, then pulses done.
module regfile_flush_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              flush_req,
    output logic              busy,
    output logic              flush_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_add,
    output logic              dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADD = '1;

    flush_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                // Requests arriving mid-flush (including on the final edge) are ignored.
                if (cnt_q == LAST_ADD) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign flush_done = done_q;
    assign clr_en     = (state_q == FLUSH);
    assign clr_add    = cnt_q;
    assign dbg_state  = logic'(state_q);

endmodule

// File: rtl/register_file_param.sv
// Parametrised GPR file: NUM_RD combinational read ports, one write port,
// optional hardwired-zero entry 0, optional write bypass, and a sequenced flush.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_add,
    input  logic [DATA_W-1:0]        write_reg,
    input  logic [NUM_RD*ADDR_W-1:0] read_add,
    output logic [NUM_RD*DATA_W-1:0] out_reg,
    output logic                     wr_accept,
    input  logic                     flush_req,
    output logic                     busy,
    output logic                     flush_done,
    output logic                     dbg_flush_state
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_add;
    logic              wr_store;

    regfile_flush_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_flush_ctrl (
        .clk        (clk),
        .clear      (clear),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .clr_en     (clr_en),
        .clr_add    (clr_add),
        .dbg_state  (dbg_flush_state)
    );

    // Writes are refused whenever the flush owns the array, so clear and write never collide.
    assign wr_accept = write_en && !busy;
    assign wr_store  = wr_accept && !((ZERO_REG != 0) && (write_add == '0));

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_add] = '0;
        end else if (wr_store) begin
            mem_d[write_add] = write_reg;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [LANE_MAX_W-1:0]        add_lane;
        logic [ADDR_W-1:0]            rd_add;
        logic [DATA_W-1:0]            rd_data;
        logic [LANE_MAX_W-ADDR_W-1:0] unused_add_bits;

        assign add_lane        = get_lane(LANE_BUS_W'(read_add), p, ADDR_W);
        assign rd_add          = add_lane[ADDR_W-1:0];
        assign unused_add_bits = add_lane[LANE_MAX_W-1:ADDR_W];

        // Zero entry wins over bypass so entry 0 can never observe write data.
        always_comb begin
            rd_data = mem_q[rd_add];
            if ((ZERO_REG != 0) && (rd_add == '0)) begin
                rd_data = '0;
            end else if ((BYPASS != 0) && wr_accept && (write_add == rd_add)) begin
                rd_data = write_reg;
            end
        end

        assign out_reg[p*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default build, a no-bypass build and a 3-port/16-entry build.
module tb_register_file_param;

    logic clk;
    logic clear;

    // Default build: ZERO_REG=1, BYPASS=1, 2 ports, 32 entries.
    logic        a_we, a_freq, a_acc, a_busy, a_done, a_dbg;
    logic [4:0]  a_wadd;
    logic [31:0] a_wreg;
    logic [9:0]  a_radd;
    logic [63:0] a_out;

    // No-bypass build.
    logic        b_we, b_freq, b_acc, b_busy, b_done, b_dbg;
    logic [4:0]  b_wadd;
    logic [31:0] b_wreg;
    logic [9:0]  b_radd;
    logic [63:0] b_out;

    // Three ports, 16 entries, no hardwired zero.
    logic        c_we, c_freq, c_acc, c_busy, c_done, c_dbg;
    logic [3:0]  c_wadd;
    logic [31:0] c_wreg;
    logic [11:0] c_radd;
    logic [95:0] c_out;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int done_cnt;

    register_file_param dut_a (
        .clk(clk), .clear(clear), .write_en(a_we), .write_add(a_wadd), .write_reg(a_wreg),
        .read_add(a_radd), .out_reg(a_out), .wr_accept(a_acc), .flush_req(a_freq),
        .busy(a_busy), .flush_done(a_done), .dbg_flush_state(a_dbg)
    );

    register_file_param #(.BYPASS(0)) dut_b (
        .clk(clk), .clear(clear), .write_en(b_we), .write_add(b_wadd), .write_reg(b_wreg),
        .read_add(b_radd), .out_reg(b_out), .wr_accept(b_acc), .flush_req(b_freq),
        .busy(b_busy), .flush_done(b_done), .dbg_flush_state(b_dbg)
    );

    register_file_param #(.ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut_c (
        .clk(clk), .clear(clear), .write_en(c_we), .write_add(c_wadd), .write_reg(c_wreg),
        .read_add(c_radd), .out_reg(c_out), .wr_accept(c_acc), .flush_req(c_freq),
        .busy(c_busy), .flush_done(c_done), .dbg_flush_state(c_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    // Driver tasks: all stimulus changes 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
        a_we   = 1'b1;
        a_wadd = addr;
        a_wreg = data;
        tick();
        a_we = 1'b0;
    endtask

    task automatic c_write(input logic [3:0] addr, input logic [31:0] data);
        c_we   = 1'b1;
        c_wadd = addr;
        c_wreg = data;
        tick();
        c_we = 1'b0;
    endtask

    initial begin
        clear = 1'b0;
        a_we = 1'b0; a_freq = 1'b0; a_wadd = '0; a_wreg = '0; a_radd = {5'd1, 5'd5};
        b_we = 1'b0; b_freq = 1'b0; b_wadd = '0; b_wreg = '0; b_radd = '0;
        c_we = 1'b0; c_freq = 1'b0; c_wadd = '0; c_wreg = '0; c_radd = '0;

        // Reset state
        #12;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_state", 32'(a_dbg), 32'd0);
        check("rst_lane0", a_out[31:0], 32'd0);
        check("rst_lane1", a_out[63:32], 32'd0);
        clear = 1'b1;
        tick();

        // Basic write then read on both ports
        a_radd = {5'd5, 5'd5};
        a_write(5'd5, 32'hDEADBEEF);
        check("wr5_lane0", a_out[31:0], 32'hDEADBEEF);
        check("wr5_lane1", a_out[63:32], 32'hDEADBEEF);

        // Hardwired zero entry
        a_we = 1'b1; a_wadd = 5'd0; a_wreg = 32'h12345678; a_radd = {5'd5, 5'd0};
        #1;
        check("zero_accept", 32'(a_acc), 32'd1);
        check("zero_same_cycle", a_out[31:0], 32'd0);
        tick();
        a_we = 1'b0;
        #1;
        check("zero_after", a_out[31:0], 32'd0);
        check("zero_other_lane", a_out[63:32], 32'hDEADBEEF);
        tick();

        // Bypass vs no bypass
        a_radd = {5'd0, 5'd7}; b_radd = {5'd0, 5'd7};
        a_we = 1'b1; a_wadd = 5'd7; a_wreg = 32'hA5A5A5A5;
        b_we = 1'b1; b_wadd = 5'd7; b_wreg = 32'hA5A5A5A5;
        #1;
        check("bypass_same", a_out[31:0], 32'hA5A5A5A5);
        check("nobypass_same", b_out[31:0], 32'd0);
        tick();
        a_we = 1'b0; b_we = 1'b0;
        #1;
        check("bypass_next", a_out[31:0], 32'hA5A5A5A5);
        check("nobypass_next", b_out[31:0], 32'hA5A5A5A5);
        tick();

        // Fill with addr+1, then flush
        for (int i = 0; i < 32; i++) a_write(5'(i), 32'(i + 1));
        a_radd = {5'd0, 5'd31};
        #1;
        check("fill_31", a_out[31:0], 32'd32);
        check("fill_0", a_out[63:32], 32'd0);
        a_freq = 1'b1;
        tick();
        a_freq = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_busy) busy_cnt++;
            if (a_done) done_cnt++;
            if (i == 5) begin
                a_we = 1'b1; a_wadd = 5'd2; a_wreg = 32'h00000BAD; a_radd = {5'd5, 5'd4};
                #1;
                check("flush_wr_refused", 32'(a_acc), 32'd0);
                check("flush_cleared_4", a_out[31:0], 32'd0);
                check("flush_kept_5", a_out[63:32], 32'd6);
            end
            if (i == 6) begin
                a_we = 1'b0; a_radd = {5'd0, 5'd2};
                #1;
                check("flush_wr_dropped", a_out[31:0], 32'd0);
            end
            if (i == 32) check("flush_done_pulse", 32'(a_done), 32'd1);
            tick();
        end
        check("flush_busy_cycles", 32'(busy_cnt), 32'd32);
        check("flush_done_count", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 32; i++) begin
            a_radd = {5'd0, 5'(i)};
            #1;
            check($sformatf("flushed_%0d", i), a_out[31:0], 32'd0);
        end
        tick();

        // Same-edge write and flush request; requests during flush ignored
        a_we = 1'b1; a_wadd = 5'd3; a_wreg = 32'h55; a_freq = 1'b1;
        tick();
        a_we = 1'b0; a_freq = 1'b0; a_radd = {5'd0, 5'd3};
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_busy) busy_cnt++;
            if (a_done) done_cnt++;
            if (i == 3) check("same_edge_held", a_out[31:0], 32'h55);
            if (i == 4) check("same_edge_cleared", a_out[31:0], 32'd0);
            if (i == 10 || i == 31) a_freq = 1'b1;
            if (i == 11) a_freq = 1'b0;
            if (i == 32) begin
                a_freq = 1'b0;
                check("end_busy_low", 32'(a_busy), 32'd0);
                check("end_done_high", 32'(a_done), 32'd1);
            end
            if (i == 33) check("end_req_ignored", 32'(a_busy), 32'd0);
            tick();
        end
        check("same_edge_busy_cycles", 32'(busy_cnt), 32'd32);
        check("same_edge_done_count", 32'(done_cnt), 32'd1);

        // Reset mid-flush aborts without a done pulse
        a_write(5'd25, 32'h25);
        a_radd = {5'd25, 5'd25};
        #1;
        check("pre_abort_25", a_out[31:0], 32'h25);
        tick();
        a_freq = 1'b1;
        tick();
        a_freq = 1'b0;
        repeat (10) tick();
        check("abort_busy_before", 32'(a_busy), 32'd1);
        clear = 1'b0;
        #1;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_state", 32'(a_dbg), 32'd0);
        check("abort_entry25", a_out[31:0], 32'd0);
        #1;
        clear = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_busy) busy_cnt++;
            if (a_done) done_cnt++;
        end
        check("abort_no_busy", 32'(busy_cnt), 32'd0);
        check("abort_no_pulse", 32'(done_cnt), 32'd0);

        // Three ports, 16 entries, entry 0 writable
        c_write(4'd0, 32'h11);
        c_write(4'd9, 32'h99);
        c_write(4'd15, 32'hF0);
        c_radd = {4'd0, 4'd9, 4'd15};
        #1;
        check("c_lane0", c_out[31:0], 32'hF0);
        check("c_lane1", c_out[63:32], 32'h99);
        check("c_lane2", c_out[95:64], 32'h11);
        c_we = 1'b1; c_wadd = 4'd0; c_wreg = 32'h77;
        #1;
        check("c_bypass_addr0", c_out[95:64], 32'h77);
        check("c_bypass_other", c_out[63:32], 32'h99);
        tick();
        c_we = 1'b0;
        c_freq = 1'b1;
        tick();
        c_freq = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (c_busy) busy_cnt++;
            if (c_done) done_cnt++;
            if (i == 16) check("c_done_pulse", 32'(c_done), 32'd1);
            tick();
        end
        check("c_busy_cycles", 32'(busy_cnt), 32'd16);
        check("c_done_count", 32'(done_cnt), 32'd1);
        check("c_flushed0", c_out[31:0], 32'd0);
        check("c_flushed1", c_out[63:32], 32'd0);
        check("c_flushed2", c_out[95:64], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
